// File: rtl/aes_pkg.sv
// AES shared types, FSM encoding and forward/inverse S-box tables.
// Used by the sequential SubBytes engine and its per-lane lookup.
package aes_pkg;

  typedef logic [0:127] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sb_state_e;

  typedef logic [0:255][7:0] sbox_tab_t;

  localparam sbox_tab_t AES_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam sbox_tab_t AES_INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

endpackage

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lane; inv selects the inverse table.
// Every byte value has a defined mapping in both tables.
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic      inv,
  input  aes_byte_t din,
  output aes_byte_t dout
);

  // table lookup, forward or inverse
  always_comb begin
    dout = inv ? AES_INV_SBOX[din] : AES_SBOX[din];
  end

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// Sequential SubBytes/InvSubBytes engine, LANES bytes per cycle.
// Optional lane output register: define AES_SBOX_PIPE_EN.
module aes_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [0:127] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data
);

  localparam int NG = 16 / LANES;
  localparam int CW = (NG > 1) ? $clog2(NG) : 1;
  localparam int GW = 8 * LANES;
  localparam logic [CW-1:0] LAST = CW'(NG - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 &&
      LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("LANES must be 1, 2, 4, 8 or 16");
  end

  sb_state_e      st_q;
  sb_state_e      st_d;
  logic [CW-1:0]  cnt_q;
  aes_state_t     data_q;
  logic           inv_q;
  logic [GW-1:0]  grp_in;
  logic [GW-1:0]  grp_out;
  logic [6:0]     base;
  logic           accept;
  logic           last_grp;
  logic           issue;
  logic           busy_end;

  assign accept   = (st_q == IDLE) && in_valid;
  assign last_grp = (cnt_q == LAST);
  assign base     = 7'(int'(cnt_q) * GW);
  assign grp_in   = data_q[base +: GW];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    aes_sbox_lane u_lane (
      .inv  (inv_q),
      .din  (grp_in[8*i +: 8]),
      .dout (grp_out[8*i +: 8])
    );
  end

`ifdef AES_SBOX_PIPE_EN
  logic          drain_q;
  logic          pipe_vld_q;
  logic [CW-1:0] pipe_grp_q;
  logic [GW-1:0] pipe_q;
  logic [6:0]    pipe_base;

  assign issue     = (st_q == BUSY) && !drain_q;
  assign busy_end  = (st_q == BUSY) && drain_q;
  assign pipe_base = 7'(int'(pipe_grp_q) * GW);

  // lane result register, emptied when the block completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q <= 1'b0;
      pipe_grp_q <= '0;
      pipe_q     <= '0;
    end else if (busy_end) begin
      pipe_vld_q <= 1'b0;
      pipe_grp_q <= '0;
      pipe_q     <= '0;
    end else if (issue) begin
      pipe_vld_q <= 1'b1;
      pipe_grp_q <= cnt_q;
      pipe_q     <= grp_out;
    end else begin
      pipe_vld_q <= 1'b0;
    end
  end

  // drain flag: last group issued, one write-back left
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_q <= 1'b0;
    end else if (accept) begin
      drain_q <= 1'b0;
    end else if (issue && last_grp) begin
      drain_q <= 1'b1;
    end
  end
`else
  assign issue    = (st_q == BUSY);
  assign busy_end = issue && last_grp;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  // next state and handshake outputs
  always_comb begin
    st_d      = st_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (st_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) st_d = BUSY;
      end
      BUSY: begin
        if (busy_end) st_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // block latch on accept, in-place group write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      inv_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (accept) begin
      data_q <= in_data;
      inv_q  <= in_inv;
      cnt_q  <= '0;
    end else begin
`ifdef AES_SBOX_PIPE_EN
      if (pipe_vld_q) data_q[pipe_base +: GW] <= pipe_q;
`else
      if (issue) data_q[base +: GW] <= grp_out;
`endif
      if (issue && !last_grp) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_data = (st_q == DONE) ? data_q : '0;

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Bench for aes_sub_bytes_seq against a GF(2^8) S-box model.
// Set LANES below; define AES_SBOX_PIPE_EN for the piped build.
module tb_aes_sub_bytes_seq;

  localparam int LANES = 4;
  localparam int NG    = 16 / LANES;
`ifdef AES_SBOX_PIPE_EN
  localparam int LAT = NG + 2;
`else
  localparam int LAT = NG + 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_inv;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  int total = 0;
  int bad   = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  aes_sub_bytes_seq #(.LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inv    (in_inv),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    if (a == 8'h00) r = 8'h00;
    else for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d,
                                         input logic inv);
    logic [127:0] r;
    logic [7:0]   b;
    for (int k = 0; k < 16; k++) begin
      b = d[127-8*k -: 8];
      r[127-8*k -: 8] = inv ? inv_tab[b] : fwd_tab[b];
    end
    return r;
  endfunction

  // one block: accept, latency, optional backpressure, drain
  task automatic run(input string tag, input logic [127:0] d,
                     input logic inv, input logic [127:0] exp,
                     input int hold);
    int n;
    logic [127:0] res;
    in_valid  = 1'b1;
    in_data   = d;
    in_inv    = inv;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    in_inv   = ~inv;
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, LAT);
    res = out_data;
    chk({tag, "_dat"}, res, exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk({tag, "_hold"}, out_data, res);
      chk({tag, "_noacc"}, {out_valid, in_ready}, 2'b10);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [127:0] d;
    logic         m;
    logic [127:0] v1;
    logic [127:0] v2;
    v1 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    v2 = 128'hd42711aee0bf98f1b8b45de51e415230;
    for (int i = 0; i < 256; i++) fwd_tab[i] = sbox_calc(8'(i));
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_inv    = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", in_ready, 1);
    chk("rst_ov", out_valid, 0);
    chk("rst_od", out_data, 0);
    rst = 1'b0;
    @(negedge clk);

    run("fwd", v1, 1'b0, v2, 0);
    run("inv", v2, 1'b1, v1, 0);
    run("z_fwd", {16{8'h00}}, 1'b0, {16{8'h63}}, 0);
    run("53_fwd", {16{8'h53}}, 1'b0, {16{8'hed}}, 0);
    run("63_inv", {16{8'h63}}, 1'b1, {16{8'h00}}, 0);
    run("ff_fwd", {16{8'hff}}, 1'b0, {16{8'h16}}, 0);
    run("bp", v1, 1'b0, v2, 10);
    run("bp2", v2, 1'b1, v1, 0);

    in_valid = 1'b1;
    in_data  = {16{8'haa}};
    in_inv   = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_rdy", in_ready, 1);
    chk("abort_ov", out_valid, 0);
    chk("abort_od", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run("post_rst", v1, 1'b0, v2, 0);

    for (int t = 0; t < 24; t++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      run("rnd", d, m, model(d, m), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
